sfifo_uart_tx: RTL and testbench
================================

SFIFO_UART_TX -- requirements
Module: sfifo_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16: clock cycles per UART bit, legal range 2..65535.
REQ-002 SHALL have port CLK, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port RST, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have port empty, input, 1 bit: FIFO empty flag, combinational from FIFO pointers.
REQ-005 SHALL have port iData, input, 8 bits: FIFO registered read data, valid from the edge that samples read=1.
REQ-006 SHALL have port read, output, 1 bit: FIFO pop strobe, driven directly from a flop.
REQ-007 SHALL have port txd, output, 1 bit: UART serial line, idle high.
REQ-008 SHALL have port busy, output, 1 bit: high from the FETCH state through the end of the STOP bit.

Function
REQ-009 SHALL implement the FSM states IDLE, FETCH, CAPT, START, DATA and STOP.
REQ-010 IDLE with empty=0 SHALL set read=1 for the next cycle and go to FETCH.
- IDLE with empty=1 SHALL stay in IDLE.
REQ-011 FETCH SHALL last exactly 1 cycle with read=1, then go to CAPT with read=0.
- read SHALL never be high for 2 consecutive cycles.
REQ-012 CAPT SHALL last 1 cycle, load iData into an 8-bit shift register at its closing edge, and go to START.
REQ-013 START SHALL hold txd=0 for CLKS_PER_BIT cycles.
REQ-014 DATA SHALL shift out 8 bits LSB first, each held CLKS_PER_BIT cycles, using a 3-bit bit index.
REQ-015 STOP SHALL hold txd=1 for CLKS_PER_BIT cycles, then go to IDLE.
REQ-016 The baud counter SHALL be sized ceil(log2(CLKS_PER_BIT)) bits, clear on every state entry, and wrap at CLKS_PER_BIT-1.
REQ-017 Frame length SHALL be exactly 10*CLKS_PER_BIT cycles (START through STOP).
- Back-to-back frames SHALL be separated by exactly 3 cycles at txd=1 (IDLE, FETCH, CAPT).
REQ-018 txd SHALL be registered and glitch-free; txd=1 in IDLE, FETCH and CAPT.
REQ-019 The block SHALL issue no read while empty=1.
- Changes of empty outside IDLE SHALL be ignored.
REQ-020 A FIFO write that arrives while a frame is in progress SHALL NOT affect the current frame.
- It SHALL be picked up at the next IDLE.

Reset
REQ-021 While RST=1, outputs SHALL be read=0, txd=1, busy=0; state SHALL be IDLE; counters and shift register SHALL be 0.
REQ-022 RST asserted mid-frame SHALL abort the frame immediately (txd=1 asynchronously).
- After release, the block SHALL restart from IDLE without resending the aborted byte.
REQ-023 The first read after RST deassertion SHALL occur no earlier than the second rising edge.

Structure
REQ-024 A shared package sfifo_uart_pkg SHALL hold the state enum, FRAME_BITS=10 and DATA_BITS=8.
REQ-025 Baud timing SHALL be a sub-module sfifo_uart_baud: counter with clear input, parameter CLKS_PER_BIT, 1-cycle tick output.
REQ-026 The top level SHALL contain only the FSM, shift register, bit index and output flops.

Verification
REQ-027 CLKS_PER_BIT=4, FIFO preloaded with 0xA5, RST released:
- one read pulse;
- txd = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles;
- busy high for 43 cycles.
REQ-028 FIFO preloaded with 0x00 and 0xFF: two frames separated by exactly 3 idle-high cycles; exactly 2 read pulses total; empty=1 afterwards, and read stays 0 for 100 further cycles.
REQ-029 empty held at 1 for 200 cycles: read=0, txd=1 and busy=0 throughout.
REQ-030 RST asserted at cycle 15 of a 0x3C frame (CLKS_PER_BIT=4):
- txd=1 the same cycle;
- after release with 0x81 queued, the next frame carries 0x81 only.
REQ-031 Byte 0x55 written into the FIFO during DATA of a 0xF0 frame: the 0xF0 frame completes unchanged, then 0x55 is sent after the 3-cycle gap.
REQ-032 CLKS_PER_BIT=2 (minimum), byte 0x01: frame length 20 cycles, bit 0 = 1, remaining data bits 0.

Source files
------------

// File: rtl/sfifo_uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter.
package sfifo_uart_pkg;

    localparam int unsigned FRAME_BITS = 10;
    localparam int unsigned DATA_BITS  = FRAME_BITS - 2;
    localparam int unsigned BIT_IDX_W  = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_CAPT  = 3'd2,
        ST_START = 3'd3,
        ST_DATA  = 3'd4,
        ST_STOP  = 3'd5
    } state_t;

endpackage

// File: rtl/sfifo_uart_baud.sv
// Bit-period counter: clears on request, wraps at CLKS_PER_BIT-1, ticks on the last cycle.
module sfifo_uart_baud #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick_c
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    // Count cycles within the current bit; restart on clear or after the last cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear || (cnt == LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick_c = (cnt == LAST);

endmodule

// File: rtl/sfifo_uart_tx.sv
// UART transmitter that pops bytes from a registered-read FIFO and sends 8N1 frames.
module sfifo_uart_tx
    import sfifo_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       empty,
    input  logic [7:0] iData,
    output logic       read,
    output logic       txd,
    output logic       busy
);

    state_t                 state;
    state_t                 state_next;
    logic [DATA_BITS-1:0]   shreg;
    logic [DATA_BITS-1:0]   shreg_next;
    logic [BIT_IDX_W-1:0]   bit_idx;
    logic [BIT_IDX_W-1:0]   bit_idx_next;
    logic                   read_next;
    logic                   txd_next;
    logic                   busy_next;
    logic                   armed;
    logic                   baud_clear;
    logic                   baud_tick;

    sfifo_uart_baud #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk    (CLK),
        .rst    (RST),
        .clear  (baud_clear),
        .tick_c (baud_tick)
    );

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, datapath updates and next values of the output flops.
    always_comb begin
        state_next   = state;
        shreg_next   = shreg;
        bit_idx_next = bit_idx;
        read_next    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (!empty && armed) begin
                    state_next = ST_FETCH;
                    read_next  = 1'b1;
                end
            end
            ST_FETCH: state_next = ST_CAPT;
            ST_CAPT: begin
                shreg_next   = iData;
                bit_idx_next = '0;
                state_next   = ST_START;
            end
            ST_START: begin
                if (baud_tick) state_next = ST_DATA;
            end
            ST_DATA: begin
                if (baud_tick) begin
                    if (bit_idx == BIT_IDX_W'(DATA_BITS - 1)) begin
                        state_next = ST_STOP;
                    end else begin
                        bit_idx_next = bit_idx + BIT_IDX_W'(1);
                        shreg_next   = {1'b0, shreg[DATA_BITS-1:1]};
                    end
                end
            end
            ST_STOP: begin
                if (baud_tick) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase

        baud_clear = (state_next != state);

        unique case (state_next)
            ST_START: txd_next = 1'b0;
            ST_DATA:  txd_next = shreg_next[0];
            default:  txd_next = 1'b1;
        endcase

        // busy stays up through the closing edge of STOP, so it drops one cycle after txd idles.
        busy_next = (state_next != ST_IDLE) || (state != ST_IDLE);
    end

    // Shift register and bit index.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            shreg   <= '0;
            bit_idx <= '0;
        end else begin
            shreg   <= shreg_next;
            bit_idx <= bit_idx_next;
        end
    end

    // Output flops; armed holds off the first pop until the second edge after reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            read  <= 1'b0;
            txd   <= 1'b1;
            busy  <= 1'b0;
            armed <= 1'b0;
        end else begin
            read  <= read_next;
            txd   <= txd_next;
            busy  <= busy_next;
            armed <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sfifo_uart_tx.sv
// Directed bench for sfifo_uart_tx: FIFO model on a CLKS_PER_BIT=4 instance, direct drive on a =2 instance.
module tb_sfifo_uart_tx;

    logic       CLK;
    logic       RST;
    logic       empty;
    logic [7:0] iData;
    logic       read;
    logic       txd;
    logic       busy;

    logic       empty2;
    logic [7:0] iData2;
    logic       read2;
    logic       txd2;
    logic       busy2;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] mem [0:15];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int underflow = 0;
    int double_read = 0;
    logic prev_read = 1'b0;

    logic txd_log  [0:255];
    logic read_log [0:255];
    logic busy_log [0:255];

    int idx;
    int idx2;

    sfifo_uart_tx #(.CLKS_PER_BIT(4)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .empty (empty),
        .iData (iData),
        .read  (read),
        .txd   (txd),
        .busy  (busy)
    );

    sfifo_uart_tx #(.CLKS_PER_BIT(2)) dut2 (
        .CLK   (CLK),
        .RST   (RST),
        .empty (empty2),
        .iData (iData2),
        .read  (read2),
        .txd   (txd2),
        .busy  (busy2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    assign empty  = (wr_ptr == rd_ptr);
    assign iData2 = 8'h01;

    // FIFO model: registered read data, popped on the edge that samples read=1.
    always @(posedge CLK) begin
        if (read) begin
            iData  <= mem[rd_ptr % 16];
            rd_ptr <= rd_ptr + 1;
        end
        if (read && empty) underflow <= underflow + 1;
        if (read && prev_read) double_read <= double_read + 1;
        prev_read <= read;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr % 16] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic capture(input int n, input int inject_at, input logic [7:0] inject_byte);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            txd_log[i]  = txd;
            read_log[i] = read;
            busy_log[i] = busy;
            if (i == inject_at) push(inject_byte);
        end
    endtask

    function automatic int count_hi(input int which, input int from, input int to);
        int c = 0;
        for (int i = from; i <= to; i++) begin
            if (which == 0 && txd_log[i] === 1'b1)  c++;
            if (which == 1 && read_log[i] === 1'b1) c++;
            if (which == 2 && busy_log[i] === 1'b1) c++;
        end
        return c;
    endfunction

    function automatic int find_fall(input int from, input int n);
        for (int i = from; i < n; i++) begin
            if (txd_log[i] === 1'b0) return i;
        end
        return -1;
    endfunction

    task automatic check_frame(input string tag, input int start, input logic [7:0] b, input int cpb);
        logic exp;
        int s;
        s = (start < 0) ? 0 : start;
        for (int k = 0; k < 10; k++) begin
            if (k == 0)      exp = 1'b0;
            else if (k == 9) exp = 1'b1;
            else             exp = b[k-1];
            for (int c = 0; c < cpb; c++) begin
                check($sformatf("%s bit%0d cyc%0d", tag, k, c), 32'(txd_log[s + k*cpb + c]), 32'(exp));
            end
        end
    endtask

    initial begin
        RST    = 1'b1;
        empty2 = 1'b1;
        push(8'hA5);

        // Reset values.
        repeat (2) @(negedge CLK);
        check("rst read", 32'(read), 32'd0);
        check("rst txd",  32'(txd),  32'd1);
        check("rst busy", 32'(busy), 32'd0);

        // Single 0xA5 frame after reset release.
        RST = 1'b0;
        capture(60, -1, 8'h00);
        check("a5 no read at first edge", 32'(read_log[0]), 32'd0);
        check("a5 read at second edge", 32'(read_log[1]), 32'd1);
        check("a5 read pulses", 32'(count_hi(1, 0, 59)), 32'd1);
        idx = find_fall(0, 60);
        check("a5 start index", 32'(idx), 32'd3);
        check_frame("a5", idx, 8'hA5, 4);
        check("a5 busy cycles", 32'(count_hi(2, 0, 59)), 32'd43);
        check("a5 idle after", 32'(count_hi(0, 43, 59)), 32'd17);

        // Back-to-back 0x00 and 0xFF.
        push(8'h00);
        push(8'hFF);
        capture(150, -1, 8'h00);
        idx = find_fall(0, 150);
        check("b2b first start", 32'(idx), 32'd2);
        check_frame("b2b 00", idx, 8'h00, 4);
        idx2 = find_fall(42, 150);
        check("b2b gap", 32'(idx2 - (idx + 40)), 32'd3);
        check_frame("b2b ff", idx2, 8'hFF, 4);
        check("b2b read pulses", 32'(count_hi(1, 0, 149)), 32'd2);
        check("b2b empty after", 32'(empty), 32'd1);
        check("b2b no read 100 cycles", 32'(count_hi(1, 44, 149)), 32'd0);

        // Empty FIFO held for 200 cycles.
        capture(200, -1, 8'h00);
        check("empty read", 32'(count_hi(1, 0, 199)), 32'd0);
        check("empty txd", 32'(count_hi(0, 0, 199)), 32'd200);
        check("empty busy", 32'(count_hi(2, 0, 199)), 32'd0);

        // Reset at frame cycle 15 of 0x3C, then 0x81 queued.
        push(8'h3C);
        repeat (17) @(negedge CLK);
        check("abort pre txd", 32'(txd), 32'd1);
        check("abort pre busy", 32'(busy), 32'd1);
        #2 RST = 1'b1;
        #1;
        check("abort txd", 32'(txd), 32'd1);
        check("abort busy", 32'(busy), 32'd0);
        check("abort read", 32'(read), 32'd0);
        repeat (2) @(negedge CLK);
        push(8'h81);
        RST = 1'b0;
        capture(60, -1, 8'h00);
        idx = find_fall(0, 60);
        check("post abort start", 32'(idx), 32'd3);
        check_frame("post abort 81", idx, 8'h81, 4);
        check("post abort reads", 32'(count_hi(1, 0, 59)), 32'd1);
        check("post abort idle", 32'(count_hi(0, 43, 59)), 32'd17);

        // 0x55 written during DATA of a 0xF0 frame.
        push(8'hF0);
        capture(120, 20, 8'h55);
        idx = find_fall(0, 120);
        check("wr mid start", 32'(idx), 32'd2);
        check_frame("wr mid f0", idx, 8'hF0, 4);
        idx2 = find_fall(42, 120);
        check("wr mid gap", 32'(idx2 - (idx + 40)), 32'd3);
        check_frame("wr mid 55", idx2, 8'h55, 4);
        check("wr mid reads", 32'(count_hi(1, 0, 119)), 32'd2);

        // Minimum bit period: CLKS_PER_BIT=2, byte 0x01.
        empty2 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            txd_log[i]  = txd2;
            read_log[i] = read2;
            busy_log[i] = busy2;
            if (read2) empty2 = 1'b1;
        end
        idx = find_fall(0, 40);
        check("cpb2 start", 32'(idx), 32'd2);
        check_frame("cpb2 01", idx, 8'h01, 2);
        check("cpb2 low cycles", 32'(40 - count_hi(0, 0, 39)), 32'd16);
        check("cpb2 reads", 32'(count_hi(1, 0, 39)), 32'd1);
        check("cpb2 busy", 32'(count_hi(2, 0, 39)), 32'd23);

        check("fifo underflow", 32'(underflow), 32'd0);
        check("consecutive reads", 32'(double_read), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
